// File: rtl/controlador_mult_escalar_pkg.sv
// Shared constants and types for the sequential scalar-by-matrix multiply controller.
package controlador_mult_escalar_pkg;

  localparam int unsigned N_ELEM = 25;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned MAT_W  = N_ELEM * ELEM_W;
  localparam int unsigned IDX_W  = 5;
  // Wide enough to hold idx + LANES for any legal LANES without wrapping.
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef logic signed [ELEM_W-1:0] elem_t;

endpackage

// File: rtl/controlador_mult_escalar_if.sv
// Request/result bundle between the operation FSM and the scalar multiply controller.
interface controlador_mult_escalar_if;
  import controlador_mult_escalar_pkg::*;

  logic             start;
  logic [MAT_W-1:0] matriz_A;
  elem_t            num_inteiro;
  logic [MAT_W-1:0] nova_matriz_A;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, matriz_A, num_inteiro,
    input  nova_matriz_A, busy, done, overflow
  );

  modport slave (
    input  start, matriz_A, num_inteiro,
    output nova_matriz_A, busy, done, overflow
  );

endinterface

// File: rtl/controlador_mult_escalar_elemento_mult_sat.sv
// One multiplier lane: signed 8x8 product reduced to 8 bits.
// MULT_SATURACAO_EN selects clamping with an overflow bit; otherwise two's-complement wrap.
module elemento_mult_sat
  import controlador_mult_escalar_pkg::*;
(
  input  elem_t elem,
  input  elem_t escalar,
  output elem_t res_c,
  output logic  ovf_c
);

`ifdef MULT_SATURACAO_EN
  localparam int unsigned PROD_W = 2 * ELEM_W;

  logic signed [PROD_W-1:0] prod;

  // Full-width product, clamped into the 8-bit signed range.
  always_comb begin
    prod  = PROD_W'(elem) * PROD_W'(escalar);
    res_c = elem_t'(prod);
    ovf_c = 1'b0;
    if (prod > PROD_W'(127)) begin
      res_c = elem_t'(127);
      ovf_c = 1'b1;
    end else if (prod < PROD_W'(-128)) begin
      res_c = elem_t'(-128);
      ovf_c = 1'b1;
    end
  end
`else
  // Low 8 bits of the product, same as the combinational scalar multiplier.
  assign res_c = elem * escalar;
  assign ovf_c = 1'b0;
`endif

endmodule

// File: rtl/controlador_mult_escalar.sv
// Sequential scalar-by-matrix multiply controller: captures a 5x5 matrix and a scalar on start,
// then streams elements through LANES shared multipliers. Optional macro: MULT_SATURACAO_EN.
module controlador_mult_escalar
  import controlador_mult_escalar_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input logic                      clk,
  input logic                      reset,
  controlador_mult_escalar_if.slave bus
);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             busy_d, done_d;
  logic             capture_c, calc_c, last_c;

  elem_t op_q  [N_ELEM];
  elem_t res_q [N_ELEM];
  elem_t esc_q;
  logic  busy_q, done_q, ovf_q;

  logic [CNT_W-1:0] slot_c     [LANES];
  logic             lane_ok_c  [LANES];
  logic             lane_we_c  [LANES];
  logic [IDX_W-1:0] sel_c      [LANES];
  elem_t            lane_res_c [LANES];
  logic [LANES-1:0] lane_raw_ovf_c;
  logic [LANES-1:0] lane_ovf_c;

  // Lane k handles slot idx+k; slots past the matrix end are masked.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign slot_c[k]     = CNT_W'(idx) + CNT_W'(k);
    assign lane_ok_c[k]  = slot_c[k] < CNT_W'(N_ELEM);
    assign lane_we_c[k]  = calc_c && lane_ok_c[k];
    assign sel_c[k]      = lane_ok_c[k] ? IDX_W'(slot_c[k]) : '0;
    assign lane_ovf_c[k] = lane_raw_ovf_c[k] && lane_we_c[k];

    elemento_mult_sat u_lane (
      .elem    (op_q[sel_c[k]]),
      .escalar (esc_q),
      .res_c   (lane_res_c[k]),
      .ovf_c   (lane_raw_ovf_c[k])
    );
  end

  assign last_c = (CNT_W'(idx) + CNT_W'(LANES)) >= CNT_W'(N_ELEM);

  // State and index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state, index advance and registered-status decode.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    capture_c = 1'b0;
    calc_c    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture_c = 1'b1;
          idx_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        calc_c = 1'b1;
        idx_d  = idx + IDX_W'(LANES);
        if (last_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

  // Operand capture, lane result writeback and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      esc_q  <= '0;
      for (int i = 0; i < N_ELEM; i++) begin
        op_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (capture_c) begin
        esc_q <= bus.num_inteiro;
        ovf_q <= 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
          op_q[i] <= bus.matriz_A[i*ELEM_W +: ELEM_W];
        end
      end
      if (calc_c) begin
        ovf_q <= ovf_q | (|lane_ovf_c);
        for (int k = 0; k < LANES; k++) begin
          if (lane_we_c[k]) res_q[sel_c[k]] <= lane_res_c[k];
        end
      end
    end
  end

  // Pack the result registers onto the output bus.
  always_comb begin
    bus.nova_matriz_A = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      bus.nova_matriz_A[i*ELEM_W +: ELEM_W] = res_q[i];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_controlador_mult_escalar.sv
// Directed bench for controlador_mult_escalar with LANES = 1, 4 and 25 instances side by side.
// Expected values follow MULT_SATURACAO_EN when it is defined.
module tb_controlador_mult_escalar;

`ifdef MULT_SATURACAO_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  typedef struct {
    int dut;      // 0: LANES=1, 1: LANES=4, 2: LANES=25
    int ramp;     // 1: element i = i-12, expected = sc*(i-12)
    int fill;     // value of elements 1..24
    int e0;       // value of element 0
    int sc;       // scalar
    int exp_fill; // expected result for elements 1..24
    int exp_e0;   // expected result for element 0
    int exp_ovf;
    int exp_lat;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  controlador_mult_escalar_if i1 ();
  controlador_mult_escalar_if i4 ();
  controlador_mult_escalar_if i25 ();

  controlador_mult_escalar #(.LANES(1))  u1  (.clk(clk), .reset(reset), .bus(i1.slave));
  controlador_mult_escalar #(.LANES(4))  u4  (.clk(clk), .reset(reset), .bus(i4.slave));
  controlador_mult_escalar #(.LANES(25)) u25 (.clk(clk), .reset(reset), .bus(i25.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic set_in(input int d, input logic st, input logic [199:0] a, input logic [7:0] s);
    case (d)
      0:       begin i1.start  = st; i1.matriz_A  = a; i1.num_inteiro  = s; end
      1:       begin i4.start  = st; i4.matriz_A  = a; i4.num_inteiro  = s; end
      default: begin i25.start = st; i25.matriz_A = a; i25.num_inteiro = s; end
    endcase
  endtask

  function automatic logic [199:0] get_res(input int d);
    case (d)
      0:       return i1.nova_matriz_A;
      1:       return i4.nova_matriz_A;
      default: return i25.nova_matriz_A;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return i1.done;
      1:       return i4.done;
      default: return i25.done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return i1.busy;
      1:       return i4.busy;
      default: return i25.busy;
    endcase
  endfunction

  function automatic logic get_ovf(input int d);
    case (d)
      0:       return i1.overflow;
      1:       return i4.overflow;
      default: return i25.overflow;
    endcase
  endfunction

  function automatic logic [199:0] build(input vec_t v);
    logic [199:0] a;
    a = '0;
    for (int i = 0; i < 25; i++) begin
      if (v.ramp != 0) a[i*8 +: 8] = 8'(i - 12);
      else             a[i*8 +: 8] = 8'((i == 0) ? v.e0 : v.fill);
    end
    return a;
  endfunction

  function automatic int exp_elem(input vec_t v, input int i);
    if (v.ramp != 0) return v.sc * (i - 12);
    return (i == 0) ? v.exp_e0 : v.exp_fill;
  endfunction

  function automatic int elem_of(input logic [199:0] r, input int i);
    logic [7:0] b;
    b = r[i*8 +: 8];
    return int'($signed(b));
  endfunction

  // Pulse start once (operands scrambled after the accepting edge) and wait for done.
  task automatic run_op(input int d, input logic [199:0] a, input int s,
                        output int lat, output int busy_err);
    set_in(d, 1'b1, a, 8'(s));
    @(posedge clk); #1;
    set_in(d, 1'b0, ~a, ~8'(s));
    lat = 1;
    busy_err = 0;
    while (!get_done(d) && lat < 100) begin
      if (!get_busy(d)) busy_err++;
      @(posedge clk); #1;
      lat++;
    end
    if (!get_busy(d)) busy_err++;
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int lat, berr;
    logic [199:0] r0;
    run_op(v.dut, build(v), v.sc, lat, berr);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " busy"}, berr, 0);
    r0 = get_res(v.dut);
    check({tag, " noX"}, int'($isunknown(r0)), 0);
    for (int i = 0; i < 25; i++) begin
      check($sformatf("%s elem%0d", tag, i), elem_of(r0, i), exp_elem(v, i));
    end
    check({tag, " ovf"}, int'(get_ovf(v.dut)), v.exp_ovf);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, int'(get_done(v.dut)), 0);
    check({tag, " idle_busy"}, int'(get_busy(v.dut)), 0);
    @(posedge clk); #1;
    check({tag, " hold"}, int'(get_res(v.dut) == r0), 1);
  endtask

  initial begin
    vec_t vecs [7];
    vec_t v;
    int   dones, done_cyc;
    logic [199:0] a, r;
    logic [8:0] mask;

    total = 0;
    bad   = 0;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, '0, '0);

    vecs[0] = '{0, 0, 3, 3, 2, 6, 6, 0, 26};
    vecs[1] = '{1, 1, 0, 0, -3, 0, 0, 0, 8};
    vecs[2] = '{0, 0, 1, 100, 2, 2, (SAT != 0) ? 127 : -56, SAT, 26};
    vecs[3] = '{2, 0, -1, -1, -128, (SAT != 0) ? 127 : -128, (SAT != 0) ? 127 : -128, SAT, 2};
    vecs[4] = '{1, 0, 5, -128, -1, -5, (SAT != 0) ? 127 : -128, SAT, 8};
    vecs[5] = '{2, 0, -7, 0, 18, -126, 0, 0, 2};
    vecs[6] = '{1, 0, 100, -128, -2, (SAT != 0) ? -128 : 56, (SAT != 0) ? 127 : 0, SAT, 8};

    // Reset values
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst res d%0d", d), int'(get_res(d) == '0), 1);
      check($sformatf("rst busy d%0d", d), int'(get_busy(d)), 0);
      check($sformatf("rst done d%0d", d), int'(get_done(d)), 0);
      check($sformatf("rst ovf d%0d", d), int'(get_ovf(d)), 0);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int n = 0; n < 7; n++) do_vec(vecs[n], $sformatf("vec%0d", n));

    // Start re-pulsed during CALC is ignored
    v = vecs[0];
    a = build(v);
    set_in(0, 1'b1, a, 8'(2));
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, '0);
    dones = 0;
    done_cyc = 0;
    r = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        v.fill = 7; v.e0 = 7;
        set_in(0, 1'b1, build(v), 8'(5));
      end else if (c == 6) begin
        set_in(0, 1'b0, '0, '0);
      end
      if (get_done(0)) begin
        dones++;
        done_cyc = c;
        r = get_res(0);
      end
      @(posedge clk); #1;
    end
    check("repulse dones", dones, 1);
    check("repulse cycle", done_cyc, 26);
    for (int i = 0; i < 25; i += 6) check($sformatf("repulse elem%0d", i), elem_of(r, i), 6);

    // Asynchronous reset mid-CALC, then a clean operation
    set_in(0, 1'b1, build(vecs[0]), 8'(2));
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, '0);
    repeat (10) begin @(posedge clk); #1; end
    check("pre_rst busy", int'(get_busy(0)), 1);
    #3 reset = 1'b1;
    #1;
    check("midrst res", int'(get_res(0) == '0), 1);
    check("midrst busy", int'(get_busy(0)), 0);
    check("midrst done", int'(get_done(0)), 0);
    check("midrst ovf", int'(get_ovf(0)), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    v = '{0, 0, -2, -2, 3, -6, -6, 0, 26};
    do_vec(v, "postrst");

    // Start held high: one operation every 3 cycles with LANES=25
    v = '{2, 0, 2, 2, 3, 6, 6, 0, 2};
    set_in(2, 1'b1, build(v), 8'(3));
    mask = '0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      mask[c-1] = get_done(2);
    end
    set_in(2, 1'b0, '0, '0);
    check("held_start mask", int'(mask), int'(9'b010010010));
    check("held_start elem", elem_of(get_res(2), 24), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
